// File: rtl/phase_frame_scheduler.sv
// Framed phase-update scheduler: parses FT245 RX bytes into a masked shadow bank and
// commits the staged phases atomically on the next PWM period boundary, then acks/naks.
module phase_frame_scheduler #(
    parameter int NUM_CHANNELS = 4,
    parameter int PHASE_W      = 8,
    parameter int DATA_W       = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rxfifo_empty,
    input  logic                            rxfifo_valid,
    input  logic [DATA_W-1:0]               rxfifo_data,
    output logic                            rxfifo_rd,
    input  logic                            txfifo_full,
    output logic                            txfifo_wr,
    output logic [DATA_W-1:0]               txfifo_data,
    input  logic                            period_sync,
    output logic [NUM_CHANNELS*PHASE_W-1:0] phases,
    output logic                            commit_pulse,
    output logic                            busy,
    output logic [7:0]                      err_cnt
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [DATA_W-1:0] SOF_BYTE = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] EOF_BYTE = DATA_W'(8'h55);
    localparam logic [DATA_W-1:0] ACK_CODE = DATA_W'(8'h4B);
    localparam logic [DATA_W-1:0] NAK_CODE = DATA_W'(8'hEE);
    localparam logic [DATA_W:0]   CH_LIMIT = (DATA_W+1)'(NUM_CHANNELS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_START,
        S_COUNT,
        S_PAYLOAD,
        S_TRAILER,
        S_ARMED,
        S_ACK
    } state_t;

    state_t                  state;
    logic                    fetch_pend;
    logic [DATA_W-1:0]       start_r;
    logic [DATA_W-1:0]       remain_r;
    logic [CH_W-1:0]         wr_idx;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [NUM_CHANNELS-1:0] mask;
    logic [PHASE_W-1:0]      shadow  [NUM_CHANNELS];
    logic [PHASE_W-1:0]      phase_r [NUM_CHANNELS];

    logic            byte_ok;
    logic            parse_state;
    logic            tmo_state;
    logic            tmo_hit;
    logic            count_bad;
    logic            abort;
    logic [DATA_W:0] frame_end;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        byte_ok     = 1'b0;
        parse_state = 1'b0;
        tmo_state   = 1'b0;
        tmo_hit     = 1'b0;
        count_bad   = 1'b0;
        abort       = 1'b0;
        frame_end   = '0;

        byte_ok     = fetch_pend && rxfifo_valid;
        tmo_state   = (state == S_START) || (state == S_COUNT) ||
                      (state == S_PAYLOAD) || (state == S_TRAILER);
        parse_state = tmo_state || (state == S_HDR);
        // The frame end is computed one bit wider so START + COUNT never wraps.
        frame_end   = {1'b0, start_r} + {1'b0, rxfifo_data};
        count_bad   = (rxfifo_data == '0) || (frame_end > CH_LIMIT);
        tmo_hit     = tmo_state && !byte_ok && (tmo_cnt == TMO_LAST);
        abort       = tmo_hit ||
                      (byte_ok && (state == S_COUNT) && count_bad) ||
                      (byte_ok && (state == S_TRAILER) && (rxfifo_data != EOF_BYTE));
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_HDR;
            fetch_pend   <= 1'b0;
            start_r      <= '0;
            remain_r     <= '0;
            wr_idx       <= '0;
            tmo_cnt      <= '0;
            mask         <= '0;
            rxfifo_rd    <= 1'b0;
            txfifo_wr    <= 1'b0;
            txfifo_data  <= '0;
            commit_pulse <= 1'b0;
            err_cnt      <= '0;
            // NOTE: the shadow bank is reset explicitly, unlike a plain RAM, so a
            // reset can never leave stale staged phases that a later commit exposes.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i]  <= '0;
                phase_r[i] <= '0;
            end
        end else begin
            rxfifo_rd    <= 1'b0;
            txfifo_wr    <= 1'b0;
            commit_pulse <= 1'b0;

            // One read strobe per byte; the next strobe waits for the capture.
            if (byte_ok) begin
                fetch_pend <= 1'b0;
            end else if (parse_state && !fetch_pend && !rxfifo_empty && !abort) begin
                rxfifo_rd  <= 1'b1;
                fetch_pend <= 1'b1;
            end

            if (tmo_state && !byte_ok && !abort) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (abort) begin
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                mask        <= '0;
                txfifo_data <= NAK_CODE;
                state       <= S_ACK;
            end else begin
                unique case (state)
                    S_HDR: begin
                        if (byte_ok && (rxfifo_data == SOF_BYTE)) begin
                            state <= S_START;
                        end
                    end
                    S_START: begin
                        if (byte_ok) begin
                            start_r <= rxfifo_data;
                            state   <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (byte_ok) begin
                            remain_r <= rxfifo_data;
                            wr_idx   <= start_r[CH_W-1:0];
                            mask     <= '0;
                            state    <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (byte_ok) begin
                            shadow[wr_idx] <= rxfifo_data[PHASE_W-1:0];
                            mask[wr_idx]   <= 1'b1;
                            wr_idx         <= wr_idx + CH_W'(1);
                            remain_r       <= remain_r - DATA_W'(1);
                            if (remain_r == DATA_W'(1)) begin
                                state <= S_TRAILER;
                            end
                        end
                    end
                    S_TRAILER: begin
                        if (byte_ok) begin
                            state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        // A sync coincident with the trailer capture is seen in S_TRAILER
                        // and therefore ignored; only syncs sampled here commit.
                        if (period_sync) begin
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                if (mask[i]) begin
                                    phase_r[i] <= shadow[i];
                                end
                            end
                            mask         <= '0;
                            commit_pulse <= 1'b1;
                            txfifo_data  <= ACK_CODE;
                            state        <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (!txfifo_full) begin
                            txfifo_wr <= 1'b1;
                            state     <= S_HDR;
                        end
                    end
                    default: state <= S_HDR;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
        assign phases[g*PHASE_W +: PHASE_W] = phase_r[g];
    end

    assign busy = (state != S_HDR);

endmodule

// File: tb/tb_phase_frame_scheduler.sv
// Scoreboard bench for phase_frame_scheduler: directed frames feed an RX FIFO model,
// expected TX bytes and committed phase words are queued and checked by monitors.
module tb_phase_frame_scheduler;

    localparam int NUM_CHANNELS = 4;
    localparam int PHASE_W      = 8;
    localparam int DATA_W       = 8;
    localparam int TIMEOUT      = 1024;

    logic        clk;
    logic        rst_n;
    logic        rxfifo_empty;
    logic        rxfifo_valid;
    logic [7:0]  rxfifo_data;
    logic        rxfifo_rd;
    logic        txfifo_full;
    logic        txfifo_wr;
    logic [7:0]  txfifo_data;
    logic        period_sync;
    logic [31:0] phases;
    logic        commit_pulse;
    logic        busy;
    logic [7:0]  err_cnt;

    phase_frame_scheduler #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .PHASE_W     (PHASE_W),
        .DATA_W      (DATA_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxfifo_empty(rxfifo_empty),
        .rxfifo_valid(rxfifo_valid),
        .rxfifo_data (rxfifo_data),
        .rxfifo_rd   (rxfifo_rd),
        .txfifo_full (txfifo_full),
        .txfifo_wr   (txfifo_wr),
        .txfifo_data (txfifo_data),
        .period_sync (period_sync),
        .phases      (phases),
        .commit_pulse(commit_pulse),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] rx_mem [256];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic       staged = 1'b0;
    logic [7:0] staged_byte;
    logic       staged_last = 1'b0;
    logic       sync_at_last = 1'b0;
    int         sync_req = 0;
    int         sync_done = 0;
    int         last_sync_cyc = -10;

    logic [7:0]  exp_tx [$];
    logic [31:0] exp_ph [$];
    int          tx_wr_count = 0;
    int          commit_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RX FIFO model: data appears one cycle after the read strobe, for one cycle.
    initial begin
        logic was_staged;
        rxfifo_valid = 1'b0;
        rxfifo_data  = '0;
        rxfifo_empty = 1'b1;
        period_sync  = 1'b0;
        forever begin
            @(negedge clk);
            rxfifo_valid = 1'b0;
            period_sync  = 1'b0;
            was_staged   = staged;
            if (staged) begin
                rxfifo_valid = 1'b1;
                rxfifo_data  = staged_byte;
                staged       = 1'b0;
                if (staged_last) begin
                    period_sync   = 1'b1;
                    last_sync_cyc = cyc;
                end
            end
            if (sync_req != sync_done) begin
                period_sync   = 1'b1;
                last_sync_cyc = cyc;
                sync_done++;
            end
            if (rxfifo_rd && rst_n) begin
                check("rd_while_outstanding", 32'(was_staged), 0);
                check("rd_when_nonempty", 32'(rx_rd != rx_wr), 1);
                if (rx_rd != rx_wr) begin
                    staged_byte = rx_mem[rx_rd];
                    rx_rd++;
                    staged      = 1'b1;
                    staged_last = sync_at_last && (rx_rd == rx_wr);
                end
            end
            rxfifo_empty = (rx_rd == rx_wr);
        end
    end

    // TX monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && txfifo_wr) begin
            tx_wr_count++;
            check("tx_expected", 32'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) check("tx_byte", 32'(txfifo_data), 32'(exp_tx.pop_front()));
        end
    end

    // Commit monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && commit_pulse) begin
            commit_count++;
            check("commit_expected", 32'(exp_ph.size() != 0), 1);
            if (exp_ph.size() != 0) check("commit_phases", phases, exp_ph.pop_front());
            check("commit_latency", 32'(cyc), 32'(last_sync_cyc + 1));
        end
    end

    task automatic send(input logic [7:0] q[$]);
        foreach (q[i]) begin
            rx_mem[rx_wr] = q[i];
            rx_wr++;
        end
    endtask

    task automatic wait_consumed();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rx_rd == rx_wr && !staged && !rxfifo_valid) done = 1;
        end
        check("rx_consumed_in_time", 32'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && exp_ph.size() == 0 &&
                rx_rd == rx_wr && !staged) done = 1;
        end
        check("idle_in_time", 32'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] fr [$];
        int saved;
        rst_n       = 1'b0;
        txfifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phases", phases, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_rxfifo_rd", 32'(rxfifo_rd), 0);
        check("rst_txfifo_wr", 32'(txfifo_wr), 0);
        check("rst_txfifo_data", 32'(txfifo_data), 0);
        check("rst_commit", 32'(commit_pulse), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, commit 50 cycles after arming.
        fr = {8'hAA, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55};
        send(fr);
        wait_consumed();
        check("f1_busy_armed", 32'(busy), 1);
        repeat (50) @(negedge clk);
        check("f1_no_commit_before_sync", phases, 32'h0000_0000);
        exp_ph.push_back(32'h4030_2010);
        exp_tx.push_back(8'h4B);
        sync_req++;
        wait_idle();
        check("f1_phases", phases, 32'h4030_2010);
        check("f1_err_cnt", 32'(err_cnt), 0);

        // Partial frame; a sync coincident with the trailer must not commit.
        sync_at_last = 1'b1;
        fr = {8'hAA, 8'h02, 8'h01, 8'h7F, 8'h55};
        send(fr);
        wait_consumed();
        sync_at_last = 1'b0;
        repeat (5) @(negedge clk);
        check("f2_entry_sync_ignored", phases, 32'h4030_2010);
        check("f2_busy_armed", 32'(busy), 1);
        exp_ph.push_back(32'h407F_2010);
        exp_tx.push_back(8'h4B);
        sync_req++;
        wait_idle();

        // START + COUNT = 5 > 4
        exp_tx.push_back(8'hEE);
        fr = {8'hAA, 8'h03, 8'h02};
        send(fr);
        wait_idle();
        check("badcnt_err_cnt", 32'(err_cnt), 1);
        check("badcnt_phases", phases, 32'h407F_2010);

        // Next good frame is accepted.
        fr = {8'hAA, 8'h01, 8'h01, 8'h5A, 8'h55};
        send(fr);
        wait_consumed();
        exp_ph.push_back(32'h407F_5A10);
        exp_tx.push_back(8'h4B);
        sync_req++;
        wait_idle();

        // Garbage before the header, then a bad trailer.
        exp_tx.push_back(8'hEE);
        fr = {8'h12, 8'h34, 8'hAA, 8'h00, 8'h01, 8'h11, 8'h56};
        send(fr);
        wait_idle();
        check("badtrl_err_cnt", 32'(err_cnt), 2);
        check("badtrl_phases", phases, 32'h407F_5A10);

        // COUNT == 0
        exp_tx.push_back(8'hEE);
        fr = {8'hAA, 8'h00, 8'h00};
        send(fr);
        wait_idle();
        check("zerocnt_err_cnt", 32'(err_cnt), 3);

        // The discarded shadow write to ch0 (0x11) must not leak into this commit.
        fr = {8'hAA, 8'h03, 8'h01, 8'h99, 8'h55};
        send(fr);
        wait_consumed();
        exp_ph.push_back(32'h997F_5A10);
        exp_tx.push_back(8'h4B);
        sync_req++;
        wait_idle();

        // RX stall after AA 00 with the TX FIFO full.
        txfifo_full = 1'b1;
        saved = tx_wr_count;
        fr = {8'hAA, 8'h00};
        send(fr);
        wait_consumed();
        repeat (TIMEOUT - 20) @(negedge clk);
        check("tmo_not_yet_err_cnt", 32'(err_cnt), 3);
        check("tmo_not_yet_busy", 32'(busy), 1);
        repeat (40) @(negedge clk);
        check("tmo_err_cnt", 32'(err_cnt), 4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("full_hold_wr", 32'(txfifo_wr), 0);
            check("full_hold_data", 32'(txfifo_data), 32'hEE);
        end
        check("full_hold_no_write", 32'(tx_wr_count), 32'(saved));
        exp_tx.push_back(8'hEE);
        txfifo_full = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("full_release_single_write", 32'(tx_wr_count), 32'(saved + 1));
        check("tmo_phases", phases, 32'h997F_5A10);

        // Reset while armed: asynchronous clear, then no commit on a later sync.
        fr = {8'hAA, 8'h00, 8'h01, 8'h22, 8'h55};
        send(fr);
        wait_consumed();
        check("rstarm_busy", 32'(busy), 1);
        saved = commit_count;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstarm_async_busy", 32'(busy), 0);
        check("rstarm_async_phases", phases, 0);
        check("rstarm_async_err_cnt", 32'(err_cnt), 0);
        check("rstarm_async_txdata", 32'(txfifo_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sync_req++;
        repeat (10) @(negedge clk);
        check("rstarm_no_commit", 32'(commit_count), 32'(saved));
        check("rstarm_phases", phases, 0);

        check("tx_queue_drained", 32'(exp_tx.size()), 0);
        check("phase_queue_drained", 32'(exp_ph.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
